// File: rtl/user_au_pkg.sv
// Shared definitions for the LPF cascade configuration controller: OBI types,
// register map, CTRL/STATUS bit positions, FSM states and a byte-enable merge helper.
package user_au_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [0:0]  aid;
  } user_au_obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
  } user_au_obi_rsp_t;

  // Word offsets (addr[7:2])
  localparam logic [5:0] REG_CTRL      = 6'd0;
  localparam logic [5:0] REG_STATUS    = 6'd1;
  localparam logic [5:0] REG_CNT       = 6'd2;
  localparam logic [5:0] REG_COEF_BASE = 6'd4;

  localparam int unsigned CTRL_COMMIT_BIT    = 0;
  localparam int unsigned CTRL_BYPASS_LSB    = 8;
  localparam int unsigned STATUS_PENDING_BIT = 0;
  localparam int unsigned STATUS_APPLIED_BIT = 1;

  typedef enum logic [1:0] {IDLE, DRAIN, APPLY} lpf_cfg_state_e;

  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/user_au_obi_regif.sv
// OBI slave front end: always grants, registers rvalid/rdata/rid/err one cycle after
// the request, and exposes a flat write-strobe/address/data/byte-enable interface.
module user_au_obi_regif
  import user_au_pkg::*;
#(
  parameter obi_cfg_t ObiCfg    = ObiDefaultConfig,
  parameter type      obi_req_t = user_au_obi_req_t,
  parameter type      obi_rsp_t = user_au_obi_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  obi_req_t    obi_req_i,
  output obi_rsp_t    obi_rsp_o,
  output logic        we_o,
  output logic [5:0]  addr_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  input  logic [31:0] rdata_i,
  input  logic        err_i
);

  logic                      rvalid_q;
  logic                      err_q;
  logic [31:0]               rdata_q;
  logic [ObiCfg.IdWidth-1:0] rid_q;
  logic                      unused_addr;

  assign we_o        = obi_req_i.req & obi_req_i.we;
  assign addr_o      = obi_req_i.addr[7:2];
  assign wdata_o     = obi_req_i.wdata;
  assign be_o        = obi_req_i.be;
  // Only the 256-byte window is decoded; the crossbar has already selected this block.
  assign unused_addr = ^{obi_req_i.addr[31:8], obi_req_i.addr[1:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
    end else begin
      rvalid_q <= obi_req_i.req;
      if (obi_req_i.req) begin
        rid_q   <= obi_req_i.aid;
        err_q   <= err_i;
        rdata_q <= (obi_req_i.we || err_i) ? 32'd0 : rdata_i;
      end
    end
  end

  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = 1'b1;
    obi_rsp_o.rvalid = rvalid_q;
    obi_rsp_o.rdata  = rdata_q;
    obi_rsp_o.rid    = rid_q;
    obi_rsp_o.err    = err_q;
  end

endmodule

// File: rtl/user_au_lpf_cfg_ctrl.sv
// Shadow/active coefficient controller for the LPF cascade: COMMIT stalls input, drains,
// then swaps the shadow set in atomically. USER_AU_LPF_CFG_IRQ_EN adds a sticky applied IRQ.
module user_au_lpf_cfg_ctrl
  import user_au_pkg::*;
#(
  parameter int unsigned       NUM_STAGES = 2,
  parameter int unsigned       CoefW      = 32,
  parameter logic [CoefW-1:0]  CoefRstVal = CoefW'(32'h0800_0000),
  parameter obi_cfg_t          ObiCfg     = ObiDefaultConfig,
  parameter type               obi_req_t  = user_au_obi_req_t,
  parameter type               obi_rsp_t  = user_au_obi_rsp_t
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  obi_req_t                             obi_req_i,
  output obi_rsp_t                             obi_rsp_o,
  input  logic [NUM_STAGES-1:0]                stage_busy_i,
  output logic                                 hold_o,
  output logic [NUM_STAGES-1:0][CoefW-1:0]     coef_o,
  output logic [NUM_STAGES-1:0]                bypass_o,
  output logic                                 apply_o
`ifdef USER_AU_LPF_CFG_IRQ_EN
  ,
  output logic                                 irq_o
`endif
);

  logic        we;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        err;

  lpf_cfg_state_e state_q, state_d;

  logic [NUM_STAGES-1:0][CoefW-1:0] shad_coef_q, shad_coef_d;
  logic [NUM_STAGES-1:0]            shad_byp_q, shad_byp_d;
  logic [NUM_STAGES-1:0][CoefW-1:0] coef_q;
  logic [NUM_STAGES-1:0]            byp_q;
  logic [31:0]                      cnt_q;
  logic [5:0]                       coef_idx;
  logic [31:0]                      coef_merged;
  logic                             coef_hit;
  logic                             commit_wr;

  user_au_obi_regif #(
    .ObiCfg    (ObiCfg),
    .obi_req_t (obi_req_t),
    .obi_rsp_t (obi_rsp_t)
  ) u_regif (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .obi_req_i (obi_req_i),
    .obi_rsp_o (obi_rsp_o),
    .we_o      (we),
    .addr_o    (addr),
    .wdata_o   (wdata),
    .be_o      (be),
    .rdata_i   (rdata),
    .err_i     (err)
  );

  // Addresses below the coefficient base wrap to a large index and never hit a stage.
  assign coef_idx  = addr - REG_COEF_BASE;
  assign commit_wr = we && (addr == REG_CTRL) && be[0] && wdata[CTRL_COMMIT_BIT];

`ifdef USER_AU_LPF_CFG_IRQ_EN
  logic applied_q, applied_d;
  assign irq_o = applied_q;
`endif

  // Read decode: always returns shadow state, never the active set.
  always_comb begin
    rdata    = '0;
    err      = 1'b0;
    coef_hit = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (coef_idx == 6'(k)) begin
        coef_hit = 1'b1;
        rdata    = 32'(shad_coef_q[k]);
      end
    end
    if (addr == REG_CTRL) begin
      rdata = 32'(shad_byp_q) << CTRL_BYPASS_LSB;
    end else if (addr == REG_STATUS) begin
      rdata                     = '0;
      rdata[STATUS_PENDING_BIT] = (state_q != IDLE);
`ifdef USER_AU_LPF_CFG_IRQ_EN
      rdata[STATUS_APPLIED_BIT] = applied_q;
`endif
    end else if (addr == REG_CNT) begin
      rdata = cnt_q;
    end else if (!coef_hit) begin
      err = 1'b1;
    end
  end

  // Shadow writes are accepted in every FSM state.
  always_comb begin
    shad_coef_d = shad_coef_q;
    shad_byp_d  = shad_byp_q;
    coef_merged = '0;
    if (we && (addr == REG_CTRL) && be[1]) begin
      shad_byp_d = wdata[CTRL_BYPASS_LSB +: NUM_STAGES];
    end
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (we && (coef_idx == 6'(k))) begin
        coef_merged    = apply_be(32'(shad_coef_q[k]), wdata, be);
        shad_coef_d[k] = CoefW'(coef_merged);
      end
    end
  end

`ifdef USER_AU_LPF_CFG_IRQ_EN
  // Set on APPLY takes priority over a simultaneous software clear.
  always_comb begin
    applied_d = applied_q;
    if (we && (addr == REG_STATUS) && be[0] && wdata[STATUS_APPLIED_BIT]) applied_d = 1'b0;
    if (apply_o) applied_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) applied_q <= 1'b0;
    else         applied_q <= applied_d;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit_wr) state_d = DRAIN;
      DRAIN:   if (stage_busy_i == '0) state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hold_o  = (state_q != IDLE);
    apply_o = (state_q == APPLY);
  end

  // Active set is loaded from the pre-edge shadow, so a write in the APPLY cycle misses it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shad_coef_q <= {NUM_STAGES{CoefRstVal}};
      shad_byp_q  <= '0;
      coef_q      <= {NUM_STAGES{CoefRstVal}};
      byp_q       <= '0;
      cnt_q       <= '0;
    end else begin
      shad_coef_q <= shad_coef_d;
      shad_byp_q  <= shad_byp_d;
      if (apply_o) begin
        coef_q <= shad_coef_q;
        byp_q  <= shad_byp_q;
        cnt_q  <= cnt_q + 32'd1;
      end
    end
  end

  assign coef_o   = coef_q;
  assign bypass_o = byp_q;

endmodule
